// File: rtl/code_selection_tracker.sv
// Sticky coverage bitmap of codes 1..CODES seen on a valid-qualified stream.
// The bitmap shows all-ones for one cycle, then restarts with the current hit.
module code_selection_tracker #(
  parameter int DATA_W = 6,
  parameter int CODES  = 18
) (
  input  logic              clk_1_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              data_val_i,
  output logic [CODES-1:0]  status_o
);

  logic [CODES-1:0] hit;
  logic [CODES-1:0] status_d;
  logic [CODES-1:0] status_q;

  // Full-width equality per code, so 0 and anything above CODES decode to no hit.
  always_comb begin
    hit = '0;
    for (int k = 0; k < CODES; k++) begin
      hit[k] = data_val_i && (data_i == DATA_W'(k + 1));
    end
  end

  always_comb begin
    status_d = status_q | hit;
    if (&status_q) begin
      status_d = hit;
    end
  end

  always_ff @(posedge clk_1_i) begin
    if (rst_i) begin
      status_q <= '0;
    end else begin
      status_q <= status_d;
    end
  end

  assign status_o = status_q;

endmodule

// File: tb/tb_code_selection_tracker.sv
// Self-checking bench for code_selection_tracker: directed scenarios plus a
// random soak compared against a set-of-seen-codes reference model.
module tb_code_selection_tracker;

  localparam int DATA_W = 6;
  localparam int CODES  = 18;

  logic              clk_1_i;
  logic              rst_i;
  logic [DATA_W-1:0] data_i;
  logic              data_val_i;
  logic [CODES-1:0]  status_o;

  int checks;
  int failures;

  // Reference model: which codes have been seen and how many distinct ones.
  bit seen [1:CODES];
  int nseen;

  code_selection_tracker #(.DATA_W(DATA_W), .CODES(CODES)) dut (
    .clk_1_i    (clk_1_i),
    .rst_i      (rst_i),
    .data_i     (data_i),
    .data_val_i (data_val_i),
    .status_o   (status_o)
  );

  initial clk_1_i = 1'b0;
  always #30 clk_1_i = ~clk_1_i;

  function automatic logic [CODES-1:0] model_bitmap();
    logic [CODES-1:0] m;
    m = '0;
    for (int c = 1; c <= CODES; c++) if (seen[c]) m[c-1] = 1'b1;
    return m;
  endfunction

  task automatic model_clear();
    for (int c = 1; c <= CODES; c++) seen[c] = 1'b0;
    nseen = 0;
  endtask

  task automatic model_update(input bit r, input bit v, input int d);
    if (r) begin
      model_clear();
    end else begin
      if (nseen == CODES) model_clear();
      if (v && d >= 1 && d <= CODES && !seen[d]) begin
        seen[d] = 1'b1;
        nseen++;
      end
    end
  endtask

  // Drive one edge's worth of inputs, let the edge happen, sample 1 ns later.
  task automatic cycle(input bit r, input bit v, input int d);
    rst_i      = r;
    data_val_i = v;
    data_i     = DATA_W'(d);
    @(posedge clk_1_i);
    model_update(r, v, d);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 5);
      checks++;
      if (status_o !== 18'h00000) begin
        failures++;
        $display("FAIL reset_hold[%0d] got=%h exp=%h", i, status_o, 18'h00000);
      end
    end
    cycle(0, 1, 5);
    checks++;
    if (status_o !== 18'h00010) begin
      failures++;
      $display("FAIL reset_release got=%h exp=%h", status_o, 18'h00010);
    end
  endtask

  task automatic test_sticky();
    int codes [4] = '{1, 3, 18, 3};
    logic [CODES-1:0] exp [4] = '{18'h00001, 18'h00005, 18'h20005, 18'h20005};
    cycle(1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, codes[i]);
      checks++;
      if (status_o !== exp[i]) begin
        failures++;
        $display("FAIL sticky[%0d] code=%0d got=%h exp=%h", i, codes[i], status_o, exp[i]);
      end
    end
  endtask

  task automatic test_ignored();
    bit vals [4] = '{0, 1, 1, 1};
    int dats [4] = '{7, 0, 19, 63};
    cycle(1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, vals[i], dats[i]);
      checks++;
      if (status_o !== 18'h00000) begin
        failures++;
        $display("FAIL ignored[%0d] val=%0d data=%0d got=%h exp=%h",
                 i, vals[i], dats[i], status_o, 18'h00000);
      end
    end
  endtask

  task automatic test_full_clear(input bit next_valid);
    logic [CODES-1:0] exp_after;
    cycle(1, 0, 0);
    for (int c = 1; c <= CODES; c++) begin
      cycle(0, 1, c);
      if (c == CODES - 1) begin
        checks++;
        if (status_o !== 18'h1FFFF) begin
          failures++;
          $display("FAIL almost_full got=%h exp=%h", status_o, 18'h1FFFF);
        end
      end
    end
    checks++;
    if (status_o !== 18'h3FFFF) begin
      failures++;
      $display("FAIL full got=%h exp=%h", status_o, 18'h3FFFF);
    end
    exp_after = next_valid ? 18'h00008 : 18'h00000;
    cycle(0, next_valid, 4);
    checks++;
    if (status_o !== exp_after) begin
      failures++;
      $display("FAIL auto_clear val=%0d got=%h exp=%h", next_valid, status_o, exp_after);
    end
  endtask

  task automatic test_mid_reset();
    cycle(1, 0, 0);
    cycle(0, 1, 2);
    cycle(0, 1, 9);
    checks++;
    if (status_o !== 18'h00102) begin
      failures++;
      $display("FAIL mid_accum got=%h exp=%h", status_o, 18'h00102);
    end
    cycle(1, 1, 6);
    checks++;
    if (status_o !== 18'h00000) begin
      failures++;
      $display("FAIL mid_reset got=%h exp=%h", status_o, 18'h00000);
    end
    cycle(0, 1, 6);
    checks++;
    if (status_o !== 18'h00020) begin
      failures++;
      $display("FAIL mid_after got=%h exp=%h", status_o, 18'h00020);
    end
  endtask

  // wide=0: codes 1..CODES for 5 us; wide=1: any 6-bit value plus occasional reset.
  task automatic test_random_soak(input bit wide, input int ncycles);
    bit r, v;
    int d;
    cycle(1, 0, 0);
    for (int i = 0; i < ncycles; i++) begin
      r = wide && ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 3) != 0);
      d = wide ? (($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(1, CODES))
               : $urandom_range(1, CODES);
      cycle(r, v, d);
      checks++;
      if (status_o !== model_bitmap()) begin
        failures++;
        $display("FAIL soak[%0d] rst=%0d val=%0d data=%0d got=%h exp=%h",
                 i, r, v, d, status_o, model_bitmap());
      end
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_i      = 1'b1;
    data_val_i = 1'b0;
    data_i     = '0;
    model_clear();
    test_reset();
    test_sticky();
    test_ignored();
    test_full_clear(1'b1);
    test_full_clear(1'b0);
    test_mid_reset();
    test_random_soak(1'b0, 5000 / 60);
    test_random_soak(1'b1, 3000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
